wb_arbiter: RTL

//  Writeback initiator for the integer register file: merges ALU results and load returns

---
 rtl/wb_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and load returns into the single
// regfile write port through one output register stage. It also tracks
// the destination registers that have a load outstanding, so the issue
// stage can stall reads that depend on them.
module wb_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            aluValid,
    output logic            aluReady,
    input  logic [AW-1:0]   aluRd,
    input  logic [XLEN-1:0] aluData,
    input  logic            ldValid,
    input  logic [AW-1:0]   ldRd,
    input  logic [XLEN-1:0] ldData,
    input  logic            issueLd,
    input  logic [AW-1:0]   issueRd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rs1Busy,
    output logic            rs2Busy,
    output logic            rdWriteEn,
    output logic [AW-1:0]   rd,
    output logic [XLEN-1:0] rdData,
    output logic            ldOrphan
);

    localparam logic [AW-1:0] X0 = AW'(0);

    // Registered state
    logic [NREG-1:0] pending_q,  pending_d;
    logic            we_q,       we_d;
    logic [AW-1:0]   rd_q,       rd_d;
    logic [XLEN-1:0] data_q,     data_d;
    logic            was_ld_q,   was_ld_d;
    logic            orphan_q,   orphan_d;

    // Intermediate decode
    logic            alu_ok;
    logic            alu_win;
    logic            ld_orphan_hit;

    // Combinational handshake and scoreboard lookups
    always_comb begin
        alu_ok        = ~pending_q[aluRd];
        aluReady      = ~ldValid & alu_ok;
        alu_win       = ~ldValid & aluValid & alu_ok;
        ld_orphan_hit = ldValid & (ldRd != X0) & ~pending_q[ldRd];
        rs1Busy       = (rs1 != X0) & pending_q[rs1];
        rs2Busy       = (rs2 != X0) & pending_q[rs2];
    end

    // Output stage selection: the load wins, then the ALU if there is no WAW hazard
    always_comb begin
        we_d     = 1'b0;
        rd_d     = rd_q;
        data_d   = data_q;
        was_ld_d = 1'b0;
        if (ldValid) begin
            we_d     = (ldRd != X0);
            rd_d     = ldRd;
            data_d   = ldData;
            was_ld_d = 1'b1;
        end else if (alu_win) begin
            we_d     = (aluRd != X0);
            rd_d     = aluRd;
            data_d   = aluData;
            was_ld_d = 1'b0;
        end
    end

    // Scoreboard update: clear on load writeback, then a new issue re-pends (set wins)
    always_comb begin
        pending_d = pending_q;
        if (we_q && was_ld_q) begin
            pending_d[rd_q] = 1'b0;
        end
        if (issueLd && (issueRd != X0)) begin
            pending_d[issueRd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Sticky flag for a load returning to a register with no pending bit
    always_comb begin
        orphan_d = orphan_q | ld_orphan_hit;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            was_ld_q  <= 1'b0;
            orphan_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            was_ld_q  <= was_ld_d;
            orphan_q  <= orphan_d;
        end
    end

    // Drive the regfile write port and the error flag straight from the flops
    always_comb begin
        rdWriteEn = we_q;
        rd        = rd_q;
        rdData    = data_q;
        ldOrphan  = orphan_q;
    end

endmodule
